// File: rtl/team_10_wb_master.sv
// Wishbone classic single-transfer master.
// Accepts one client request at a time, drives a single bus cycle, and
// reports completion with a one-cycle rsp_valid pulse. A bus cycle that is
// not acknowledged within TIMEOUT cycles is aborted and flagged in rsp_err.
module team_10_wb_master #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // client request / response
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_adr,
   input  logic [31:0] req_dat,
   input  logic [3:0]  req_sel,
   output logic        rsp_valid,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        busy,
   // Wishbone master
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   output logic [3:0]  sel_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i
);

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = 4;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_we;
   logic              w_we_nxt;
   logic [AW-1:0]     r_adr;
   logic [AW-1:0]     w_adr_nxt;
   logic [DW-1:0]     r_dat;
   logic [DW-1:0]     w_dat_nxt;
   logic [SW-1:0]     r_sel;
   logic [SW-1:0]     w_sel_nxt;
   logic [DW-1:0]     r_rsp_dat;
   logic [DW-1:0]     w_rsp_dat_nxt;
   logic              r_rsp_err;
   logic              w_rsp_err_nxt;
   logic              r_cyc;
   logic              r_rsp_valid;
   logic              r_busy;
   logic              r_req_ready;

   // Next-state, timeout counter, request latch and response capture.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_we_nxt      = r_we;
      w_adr_nxt     = r_adr;
      w_dat_nxt     = r_dat;
      w_sel_nxt     = r_sel;
      w_rsp_dat_nxt = r_rsp_dat;
      w_rsp_err_nxt = r_rsp_err;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_we_nxt    = req_we;
               w_adr_nxt   = req_adr;
               w_dat_nxt   = req_dat;
               w_sel_nxt   = req_sel;
               w_cnt_nxt   = '0;
               w_state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            // ack takes priority over an expiry on the same edge
            if (ack_i) begin
               w_state_nxt   = RESP;
               w_rsp_err_nxt = 1'b0;
               if (!r_we) begin
                  w_rsp_dat_nxt = dat_i;
               end
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt   = RESP;
               w_rsp_err_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register; status and bus controls are decoded from the next state
   // so every output comes straight from a flop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_adr       <= '0;
         r_dat       <= '0;
         r_sel       <= '0;
         r_rsp_dat   <= '0;
         r_rsp_err   <= 1'b0;
         r_cyc       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_req_ready <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_we        <= w_we_nxt;
         r_adr       <= w_adr_nxt;
         r_dat       <= w_dat_nxt;
         r_sel       <= w_sel_nxt;
         r_rsp_dat   <= w_rsp_dat_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_cyc       <= (w_state_nxt == ACTIVE);
         r_rsp_valid <= (w_state_nxt == RESP);
         r_busy      <= (w_state_nxt != IDLE);
         r_req_ready <= (w_state_nxt == IDLE);
      end
   end

   assign cyc_o     = r_cyc;
   assign stb_o     = r_cyc;
   assign we_o      = r_we;
   assign adr_o     = r_adr;
   assign dat_o     = r_dat;
   assign sel_o     = r_sel;
   assign rsp_valid = r_rsp_valid;
   assign rsp_dat   = r_rsp_dat;
   assign rsp_err   = r_rsp_err;
   assign busy      = r_busy;
   assign req_ready = r_req_ready;

endmodule

// File: doc/team_10_wb_master.md
TEAM_10_WB_MASTER -- requirements
Module: team_10_wb_master

Interface
REQ-001 Parameter TIMEOUT, default 64: bus cycles to wait for ack_i before aborting; legal range 2..255.
REQ-002 clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 rst_i  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 req_valid  input  1  client transaction request.
REQ-005 req_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_adr  input  32  byte address.
REQ-008 req_dat  input  32  write data.
REQ-009 req_sel  input  4  byte-lane selects.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_dat  output  32  read data; valid with rsp_valid on reads.
REQ-012 rsp_err  output  1  timeout flag; valid with rsp_valid.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 cyc_o, stb_o, we_o  output  1 each  Wishbone classic master controls.
REQ-015 adr_o  output  32; dat_o  output  32; sel_o  output  4  Wishbone master address/data/selects.
REQ-016 dat_i  input  32; ack_i  input  1  Wishbone slave read data and acknowledge.

Function
REQ-017 FSM shall have exactly three states: IDLE, ACTIVE, RESP.
REQ-018 IDLE: req_ready=1; on req_valid=1 at a clock edge, latch req_we/req_adr/req_dat/req_sel into we_o/adr_o/dat_o/sel_o, clear timeout counter, go ACTIVE.
REQ-019 ACTIVE: cyc_o=stb_o=1 from the cycle after acceptance; adr_o, dat_o, sel_o, we_o held constant for the whole ACTIVE period.
REQ-020 ACTIVE with ack_i=1 at an edge: go RESP; if we_o=0 capture dat_i into rsp_dat; rsp_err<=0; cyc_o/stb_o low from the next cycle.
REQ-021 ACTIVE without ack_i: 8-bit counter increments each cycle; at count TIMEOUT-1 without ack_i, go RESP with rsp_err<=1, rsp_dat unchanged.
REQ-022 ack_i and timeout expiry at the same edge: ack wins, rsp_err=0, read data captured.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, cyc_o=stb_o=0; unconditionally to IDLE next edge.
REQ-024 Write completions shall leave rsp_dat at its previous value.
REQ-025 ack_i in IDLE or RESP is ignored: no state, data or flag change.
REQ-026 req_valid while not IDLE ignored (req_ready=0); no queuing.
REQ-027 Latency: accept at edge N -> stb_o high cycle N+1; ack sampled at edge N+1 -> rsp_valid high cycle N+2 -> req_ready high cycle N+3 (min. 3-cycle issue-to-issue).
REQ-028 rsp_dat and rsp_err hold their values after rsp_valid falls until the next completion.

Reset
REQ-029 rst_i sampled high -> next cycle: state IDLE, cyc_o=stb_o=we_o=0, adr_o=dat_o=0, sel_o=0, rsp_valid=0, rsp_err=0, rsp_dat=0, busy=0, req_ready=1, counter=0.
REQ-030 rst_i during ACTIVE or RESP aborts the transaction: cyc_o/stb_o low the next cycle, no rsp_valid pulse for it.
REQ-031 rst_i has priority over req_valid and ack_i at the same edge.

Verification
REQ-032 Write: req adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF, we=1; slave acks first bus cycle -> bus shows those values with stb_o=1 one cycle, rsp_valid pulse 2 cycles after accept, rsp_err=0.
REQ-033 Read: adr=0x3000_0008, we=0; slave acks after 3 wait cycles with dat_i=0x12345678 -> rsp_dat=0x12345678, rsp_valid one cycle, bus signals stable throughout.
REQ-034 Timeout: TIMEOUT=8, slave never acks -> stb_o high exactly 8 cycles, then rsp_valid=1 with rsp_err=1, rsp_dat unchanged.
REQ-035 Ack on timeout cycle: TIMEOUT=8, ack_i at 8th stb cycle with dat_i=0xA5A5A5A5 -> rsp_err=0, rsp_dat=0xA5A5A5A5.
REQ-036 Reset mid-read: rst_i pulsed in 2nd ACTIVE cycle -> cyc_o/stb_o=0 next cycle, no rsp_valid, req_ready=1; a following read completes normally.
REQ-037 Back-to-back: req_valid held high for two requests, stray ack_i in IDLE -> second accepted at earliest 3 cycles after first, stray ack ignored.
